// File: rtl/uart_tx_framer.sv
// UART transmit framer: 8N1 serial frames, or 8E1 when UART_TX_PARITY_EN is defined.
// Also holds the low seven bits of the last completed byte for the hex-display decoder.
module uart_tx_framer #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [6:0] disp_data
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DISP_W = 7;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [IDX_W-1:0]    bit_idx;
    logic [BYTE_W-1:0]   shift_reg;
    logic [DISP_W-1:0]   held;
`ifdef UART_TX_PARITY_EN
    logic                parity;
`endif

    logic bit_end;
    assign bit_end = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Single registered FSM; every bit period is CLKS_PER_BIT cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            held      <= '0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            disp_data <= '0;
`ifdef UART_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shift_reg <= tx_data;
                        held      <= tx_data[6:0];
`ifdef UART_TX_PARITY_EN
                        parity    <= ^tx_data;
`endif
                        bit_cnt   <= '0;
                        bit_idx   <= '0;
                        tx        <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx      <= shift_reg[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == IDX_W'(7)) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            // Next bit is presented from bit 1 while the register shifts down.
                            bit_idx   <= bit_idx + IDX_W'(1);
                            tx        <= shift_reg[1];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        bit_cnt   <= '0;
                        tx_done   <= 1'b1;
                        tx_busy   <= 1'b0;
                        disp_data <= held;
                        state     <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Randomised bench for uart_tx_framer against a frame-level reference model.
module tb_uart_tx_framer;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic [6:0] disp_data;

    uart_tx_framer #(.CLKS_PER_BIT(CPB)) dut (
        .clock     (clock),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .disp_data (disp_data)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int done_cnt = 0;

    // Reference model: a frame is a list of bit values, each held CPB cycles.
    bit          m_active = 1'b0;
    int          m_k = 0;
    logic [10:0] m_bits = '0;
    logic [7:0]  m_byte = '0;
    logic        exp_tx = 1'b1;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic [6:0]  exp_disp = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic build_frame(input logic [7:0] d);
        m_bits = '0;
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
        m_bits[9]  = ^d;
        m_bits[10] = 1'b1;
`else
        m_bits[9]  = 1'b1;
`endif
    endtask

    task automatic model_edge();
        if (reset) begin
            m_active = 1'b0;
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_disp = '0;
        end else begin
            exp_done = 1'b0;
            if (m_active) begin
                m_k++;
                if (m_k == FRAME) begin
                    m_active = 1'b0;
                    exp_done = 1'b1;
                    exp_busy = 1'b0;
                    exp_tx   = 1'b1;
                    exp_disp = m_byte[6:0];
                end else begin
                    exp_tx = m_bits[m_k / CPB];
                end
            end else if (tx_start) begin
                m_active = 1'b1;
                m_k      = 0;
                m_byte   = tx_data;
                build_frame(tx_data);
                exp_tx   = 1'b0;
                exp_busy = 1'b1;
            end
        end
    endtask

    // One clock: advance the model on the edge, compare all outputs 1 time unit later.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        cycle++;
        check_eq("tx", 32'(tx), 32'(exp_tx));
        check_eq("tx_busy", 32'(tx_busy), 32'(exp_busy));
        check_eq("tx_done", 32'(tx_done), 32'(exp_done));
        check_eq("disp_data", 32'(disp_data), 32'(exp_disp));
        if (tx_done === 1'b1) done_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_pulse(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
    endtask

    initial begin
        // Reset then idle
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        done_cnt = 0;
        run(20);
        check_eq("idle_done_count", 32'(done_cnt), 32'd0);
        check_eq("idle_disp", 32'(disp_data), 32'h00);

        // Single 0x41 frame
        done_cnt = 0;
        send_pulse(8'h41);
        run(FRAME + 5);
        check_eq("f41_done_count", 32'(done_cnt), 32'd1);
        check_eq("f41_disp", 32'(disp_data), 32'h41);

        // Back-to-back with tx_start held; second byte latched despite later data churn
        done_cnt = 0;
        tx_data  = 8'hC5;
        tx_start = 1'b1;
        step();
        tx_data = 8'h12;
        run(FRAME);
        check_eq("c5_done", 32'(tx_done), 32'd1);
        check_eq("c5_disp", 32'(disp_data), 32'h45);
        step();
        check_eq("b2b_accept_busy", 32'(tx_busy), 32'd1);
        tx_start = 1'b0;
        for (int i = 0; i < FRAME + 5; i++) begin
            tx_data = 8'($urandom);
            step();
        end
        check_eq("b2b_done_count", 32'(done_cnt), 32'd2);
        check_eq("f12_disp", 32'(disp_data), 32'h12);

        // Request while busy is dropped
        done_cnt = 0;
        send_pulse(8'h55);
        run(9);
        send_pulse(8'h33);
        run(FRAME + 5);
        check_eq("busy_ign_done_count", 32'(done_cnt), 32'd1);
        check_eq("busy_ign_disp", 32'(disp_data), 32'h55);

        // Mid-frame reset aborts, next frame is clean
        done_cnt = 0;
        send_pulse(8'hFF);
        run(16);
        reset = 1'b1;
        step();
        check_eq("abort_tx", 32'(tx), 32'd1);
        reset = 1'b0;
        run(FRAME + 5);
        check_eq("abort_done_count", 32'(done_cnt), 32'd0);
        check_eq("abort_disp", 32'(disp_data), 32'h00);
        send_pulse(8'h0F);
        run(FRAME + 5);
        check_eq("f0f_done_count", 32'(done_cnt), 32'd1);
        check_eq("f0f_disp", 32'(disp_data), 32'h0F);

        // Parity-relevant bytes (odd and even weight)
        send_pulse(8'h41);
        run(FRAME + 2);
        send_pulse(8'h07);
        run(FRAME + 2);
        check_eq("f07_disp", 32'(disp_data), 32'h07);

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            tx_data  = 8'($urandom);
            tx_start = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 599) == 0);
            step();
        end
        reset    = 1'b0;
        tx_start = 1'b0;
        run(FRAME + 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
